// File: rtl/collect_fifo_wr_arb_if.sv
// Write-side bundle between the producers, the arbiter and the collector FIFO.
//
// Handshake: a producer beat moves on a rising clk edge exactly when
// req_valid[i] and req_ready[i] are both high in that cycle. A producer
// holding req_valid high must keep its req_data slot stable until it sees
// ready. The same cycle raises fifo_wr_en with that word on fifo_din.
// fifo_full=1 blocks every beat.
interface collect_fifo_wr_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;

  // Producers and the FIFO, seen from outside the arbiter.
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/collect_fifo_wr_arb.sv
// Round-robin burst arbiter for the collector FIFO write port.
// A grant lasts up to BURST_LEN beats. Each producer's words land contiguously.
// Data is steered combinationally, so the arbiter adds no latency.
module collect_fifo_wr_arb #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int BURST_LEN  = 8,
  localparam int GW         = $clog2(NUM_REQ),
  localparam int BW         = $clog2(BURST_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  collect_fifo_wr_arb_if.slave bus,
  output logic                 grant_active,
  output logic [GW-1:0]        grant_id,
  output logic [BW-1:0]        beat_cnt,
  output logic [GW-1:0]        rr_ptr
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] slot [NUM_REQ];
  logic [NUM_REQ-1:0]    ready;
  logic                  xfer;
  logic                  last_beat;
  logic                  release_grant;
  logic [GW-1:0]         next_start;
  logic [GW:0]           pick_rr;
  logic [GW:0]           pick_nx;

  // First valid requester scanning from start upward, with wrap.
  // Result is {found, index}. The loop walks backwards so the first index in
  // scan order is the one that survives.
  function automatic logic [GW:0] pick(input logic [NUM_REQ-1:0] valid,
                                       input logic [GW-1:0]      start);
    logic [GW:0] res;
    logic [GW:0] sum;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (GW+1)'(k);
      if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
      if (valid[sum[GW-1:0]]) res = {1'b1, sum[GW-1:0]};
    end
    return res;
  endfunction

  // Unpack the flat producer data bus into per-slot words.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_active = (state == GRANT);

  // Ready/transfer decode and the release decision for the current grant.
  always_comb begin
    ready = '0;
    if (grant_active && !bus.fifo_full) ready[grant_id] = 1'b1;
    xfer          = ready[grant_id] & bus.req_valid[grant_id];
    last_beat     = (beat_cnt == BW'(BURST_LEN - 1));
    release_grant = (xfer & last_beat) | ~bus.req_valid[grant_id];
    next_start    = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    pick_rr       = pick(bus.req_valid, rr_ptr);
    pick_nx       = pick(bus.req_valid, next_start);
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = slot[grant_id];

  // Grant FSM: IDLE waits for any valid. GRANT counts beats and hands over
  // on release. The hand-over happens without a bubble when another
  // requester is waiting, or when the same requester is still valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_rr[GW]) begin
            state    <= GRANT;
            grant_id <= pick_rr[GW-1:0];
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            rr_ptr   <= next_start;
            beat_cnt <= '0;
            if (pick_nx[GW]) grant_id <= pick_nx[GW-1:0];
            else             state    <= IDLE;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
